axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_slave_pkg.sv | 23 ++
 rtl/axi_sram_slave.sv | 183 ++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI-to-SRAM slave.
// Holds the FSM encoding, AXI response/burst codes and the channel widths.
package axi_slave_pkg;

  localparam int ID_W   = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int SIZE_W = 3;
  localparam int ADDR_W = 14;

  localparam logic [1:0] OKAY      = 2'b00;
  localparam logic [1:0] SLVERR    = 2'b10;
  localparam logic [1:0] BURST_INC = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI3-style slave in front of a single-port synchronous SRAM (16K x 32).
// One transaction at a time; writes win address collisions; reads take 2 cycles per beat.
module axi_sram_slave
  import axi_slave_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic [ID_W-1:0]   AWID,
  input  logic [31:0]       AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [SIZE_W-1:0] AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,

  input  logic [DATA_W-1:0] WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,

  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,

  input  logic [ID_W-1:0]   ARID,
  input  logic [31:0]       ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [SIZE_W-1:0] ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,

  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,

  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    id_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               burst_err_q;
  logic               prot_err_q;

  logic last_beat;
  logic aw_hs, ar_hs, w_hs, r_hs;

  assign last_beat = (cnt_q == len_q);
  assign aw_hs     = (state == IDLE) && AWVALID;
  assign ar_hs     = (state == IDLE) && ARVALID && !AWVALID;
  assign w_hs      = (state == WR_DATA) && WVALID;
  assign r_hs      = (state == RD_DATA) && RREADY;

  // Size, upper address bits and byte offset play no part in a 32-bit word SRAM.
  logic unused_bits;
  assign unused_bits = ^{AWADDR[31:16], AWADDR[1:0], AWSIZE,
                         ARADDR[31:16], ARADDR[1:0], ARSIZE};

  // NOTE: every register here is clocked state, so only non-blocking assignments;
  // the async reset puts the whole context back to zero so an abandoned burst leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      burst_err_q <= 1'b0;
      prot_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (aw_hs) begin
        id_q        <= AWID;
        addr_q      <= AWADDR[15:2];
        len_q       <= AWLEN;
        cnt_q       <= '0;
        burst_err_q <= (AWBURST != BURST_INC);
        prot_err_q  <= 1'b0;
      end else if (ar_hs) begin
        id_q        <= ARID;
        addr_q      <= ARADDR[15:2];
        len_q       <= ARLEN;
        cnt_q       <= '0;
        burst_err_q <= (ARBURST != BURST_INC);
        prot_err_q  <= 1'b0;
      end else if (w_hs) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q + LEN_W'(1);
        if (WLAST != last_beat) prot_err_q <= 1'b1;
      end else if (r_hs && !last_beat) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q + LEN_W'(1);
      end
    end
  end

  // Write bursts end on the beat count alone; WLAST only feeds the error flag.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (AWVALID)      state_nxt = WR_DATA;
        else if (ARVALID) state_nxt = RD_ADDR;
      end
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: if (RREADY) state_nxt = last_beat ? IDLE : RD_ADDR;
      WR_DATA: if (WVALID && last_beat) state_nxt = WR_RESP;
      WR_RESP: if (BREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: each output gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    AWREADY   = 1'b0;
    ARREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BID       = '0;
    BRESP     = OKAY;
    RVALID    = 1'b0;
    RID       = '0;
    RDATA     = '0;
    RRESP     = OKAY;
    RLAST     = 1'b0;
    sram_cs   = 1'b0;
    sram_oe   = 1'b0;
    sram_web  = 4'b1111;
    sram_addr = '0;
    sram_di   = '0;
    case (state)
      IDLE: begin
        AWREADY = 1'b1;
        ARREADY = !AWVALID;
      end
      RD_ADDR: begin
        sram_cs   = 1'b1;
        sram_oe   = 1'b1;
        sram_addr = addr_q;
      end
      RD_DATA: begin
        sram_cs   = 1'b1;
        sram_oe   = 1'b1;
        sram_addr = addr_q;
        RVALID    = 1'b1;
        RDATA     = sram_do;
        RID       = id_q;
        RLAST     = last_beat;
        RRESP     = burst_err_q ? SLVERR : OKAY;
      end
      WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          sram_cs   = 1'b1;
          sram_web  = ~WSTRB;
          sram_di   = WDATA;
          sram_addr = addr_q;
        end
      end
      WR_RESP: begin
        BVALID = 1'b1;
        BID    = id_q;
        BRESP  = (burst_err_q || prot_err_q) ? SLVERR : OKAY;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: a behavioural SRAM plus a word-array
// reference model; directed corner cases followed by randomized bursts.
module tb_axi_sram_slave;
  import axi_slave_pkg::*;

  logic        clk, rst;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        sram_cs, sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_addr;
  logic [31:0] sram_di, sram_do;

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: registered read, byte-masked write, plus a backdoor preload port.
  bit [31:0]   sram_mem [0:16383];
  int unsigned sram_writes;
  logic        pre_en;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) sram_mem[pre_addr] <= pre_data;
    if (sram_cs && sram_web != 4'hF) begin
      for (int b = 0; b < 4; b++)
        if (!sram_web[b]) sram_mem[sram_addr][8*b +: 8] <= sram_di[8*b +: 8];
      sram_writes <= sram_writes + 1;
    end
    if (sram_cs && sram_oe) sram_do <= sram_mem[sram_addr];
  end

  bit [31:0]  ref_mem [0:16383];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  logic        wlst [16];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic aw_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst);
    int n;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'($urandom_range(0, 7));
    AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    #1;
    while (!AWREADY && n < 20) begin @(negedge clk); #1; n++; end
    check("awready", {31'd0, AWREADY}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    AWVALID = 1'b0;
  endtask

  task automatic w_b_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int nbeats);
    logic [13:0] wa;
    logic [3:0]  web_exp;
    logic        perr;
    int          n, gap, dly;
    wa = addr[15:2];
    perr = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      gap = $urandom_range(0, 1);
      for (int g = 0; g < gap; g++) begin
        WVALID = 1'b0;
        #1;
        check("w_gap_cs", {31'd0, sram_cs}, 32'd0);
        @(negedge clk);
      end
      WVALID = 1'b1; WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = wlst[i];
      #1;
      web_exp = ~wstb[i];
      check("wready",  {31'd0, WREADY},  32'd1);
      check("w_cs",    {31'd0, sram_cs}, 32'd1);
      check("w_oe",    {31'd0, sram_oe}, 32'd0);
      check("w_web",   {28'd0, sram_web}, {28'd0, web_exp});
      check("w_addr",  {18'd0, sram_addr}, {18'd0, wa});
      check("w_di",    sram_di, wdat[i]);
      @(posedge clk);
      @(negedge clk);
      for (int b = 0; b < 4; b++)
        if (wstb[i][b]) ref_mem[wa][8*b +: 8] = wdat[i][8*b +: 8];
      if (wlst[i] != (i == len)) perr = 1'b1;
      wa = wa + 14'd1;
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    if (nbeats == len + 1) begin
      n = 0;
      while (!BVALID && n < 20) begin @(negedge clk); n++; end
      dly = $urandom_range(0, 3);
      for (int k = 0; k < dly; k++) @(negedge clk);
      check("bvalid", {31'd0, BVALID}, 32'd1);
      check("bid",    {24'd0, BID}, {24'd0, id});
      check("bresp",  {30'd0, BRESP}, (perr || burst != BURST_INC) ? 32'd2 : 32'd0);
      BREADY = 1'b1;
      @(posedge clk);
      @(negedge clk);
      BREADY = 1'b0;
      check("b_to_idle", {31'd0, AWREADY}, 32'd1);
    end
  endtask

  task automatic ar_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst);
    int n;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'($urandom_range(0, 7));
    ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    #1;
    while (!ARREADY && n < 20) begin @(negedge clk); #1; n++; end
    check("arready", {31'd0, ARREADY}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    ARVALID = 1'b0;
  endtask

  // Entered on the falling edge just after the AR (or previous R) handshake.
  task automatic r_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int nbeats,
                         input int stall_beat, input int stall_cyc);
    logic [13:0] wa;
    logic [31:0] resp_exp;
    int          n;
    wa = addr[15:2];
    resp_exp = (burst == BURST_INC) ? 32'd0 : 32'd2;
    for (int i = 0; i < nbeats; i++) begin
      n = 0;
      while (!RVALID && n < 20) begin @(negedge clk); n++; end
      check("r_latency", 32'(n + 1), 32'd2);
      check("rvalid", {31'd0, RVALID}, 32'd1);
      check("rdata",  RDATA, ref_mem[wa]);
      check("rid",    {24'd0, RID}, {24'd0, id});
      check("rresp",  {30'd0, RRESP}, resp_exp);
      check("rlast",  {31'd0, RLAST}, (i == len) ? 32'd1 : 32'd0);
      if (i == stall_beat) begin
        for (int k = 0; k < stall_cyc; k++) begin
          @(negedge clk);
          check("stall_rvalid", {31'd0, RVALID}, 32'd1);
          check("stall_rdata",  RDATA, ref_mem[wa]);
          check("stall_rlast",  {31'd0, RLAST}, (i == len) ? 32'd1 : 32'd0);
        end
      end
      RREADY = 1'b1;
      @(posedge clk);
      @(negedge clk);
      RREADY = 1'b0;
      wa = wa + 14'd1;
    end
  endtask

  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst);
    aw_phase(id, addr, len, burst);
    w_b_phase(id, addr, len, burst, len + 1);
  endtask

  task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int stall_beat, input int stall_cyc);
    ar_phase(id, addr, len, burst);
    r_phase(id, addr, len, burst, len + 1, stall_beat, stall_cyc);
  endtask

  task automatic fill_w(input logic [3:0] len, input bit bad_last);
    for (int i = 0; i < 16; i++) begin
      wdat[i] = $urandom;
      wstb[i] = 4'($urandom_range(0, 15));
      wlst[i] = (i == len);
      if (bad_last && $urandom_range(0, 5) == 0) wlst[i] = ~wlst[i];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned wr_before;
    logic [31:0] tmp, addr;
    logic [13:0] word;
    logic [3:0]  len;
    logic [1:0]  burst;

    rst = 1'b0;
    {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID} = '0;
    {WDATA, WSTRB, WLAST, WVALID, BREADY} = '0;
    {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY} = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_awready", {31'd0, AWREADY}, 32'd1);
    check("rst_arready", {31'd0, ARREADY}, 32'd1);
    check("rst_wready",  {31'd0, WREADY},  32'd0);
    check("rst_bvalid",  {31'd0, BVALID},  32'd0);
    check("rst_rvalid",  {31'd0, RVALID},  32'd0);
    check("rst_rlast",   {31'd0, RLAST},   32'd0);
    check("rst_ids",     {16'd0, BID, RID}, 32'd0);
    check("rst_rdata",   RDATA, 32'd0);
    check("rst_resps",   {28'd0, BRESP, RRESP}, 32'd0);
    check("rst_web",     {28'd0, sram_web}, 32'hF);
    check("rst_cs_oe",   {30'd0, sram_cs, sram_oe}, 32'd0);
    check("rst_addr_di", sram_di | {18'd0, sram_addr}, 32'd0);
    AWVALID = 1'b1;
    #1;
    check("rst_ar_gated", {31'd0, ARREADY}, 32'd0);
    AWVALID = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single read of a preloaded word
    preload(14'd4, 32'hDEADBEEF);
    read_burst(8'h5A, 32'h0000_0010, 4'd0, BURST_INC, -1, 0);

    // Four-beat write then read-back
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'(i + 1); wstb[i] = 4'hF; wlst[i] = (i == 3);
    end
    write_burst(8'h11, 32'h0000_0020, 4'd3, BURST_INC);
    read_burst(8'h12, 32'h0000_0020, 4'd3, BURST_INC, -1, 0);

    // Single byte-lane write
    preload(14'd16, 32'h11223344);
    wdat[0] = 32'h0000AB00; wstb[0] = 4'b0010; wlst[0] = 1'b1;
    wr_before = sram_writes;
    write_burst(8'h21, 32'h0000_0040, 4'd0, BURST_INC);
    check("strobe_write_count", sram_writes - wr_before, 32'd1);
    read_burst(8'h22, 32'h0000_0040, 4'd0, BURST_INC, -1, 0);

    // AW and AR together: write served first, read sees the new data
    fill_w(4'd1, 1'b0);
    wstb[0] = 4'hF; wstb[1] = 4'hF;
    @(negedge clk);
    ARID = 8'h31; ARADDR = 32'h0000_0080; ARLEN = 4'd1; ARBURST = BURST_INC; ARVALID = 1'b1;
    AWID = 8'h30; AWADDR = 32'h0000_0080; AWLEN = 4'd1; AWBURST = BURST_INC; AWVALID = 1'b1;
    #1;
    check("coll_arready", {31'd0, ARREADY}, 32'd0);
    check("coll_awready", {31'd0, AWREADY}, 32'd1);
    aw_phase(8'h30, 32'h0000_0080, 4'd1, BURST_INC);
    check("coll_wr_first", {31'd0, WREADY}, 32'd1);
    check("coll_ar_held",  {31'd0, ARREADY}, 32'd0);
    w_b_phase(8'h30, 32'h0000_0080, 4'd1, BURST_INC, 2);
    read_burst(8'h31, 32'h0000_0080, 4'd1, BURST_INC, -1, 0);

    // Read backpressure for five cycles
    read_burst(8'h40, 32'h0000_0020, 4'd1, BURST_INC, 0, 5);

    // WLAST on the first beat of a two-beat burst: both beats written, SLVERR
    fill_w(4'd1, 1'b0);
    wstb[0] = 4'hF; wstb[1] = 4'hF; wlst[0] = 1'b1; wlst[1] = 1'b1;
    wr_before = sram_writes;
    write_burst(8'h50, 32'h0000_0400, 4'd1, BURST_INC);
    check("early_wlast_count", sram_writes - wr_before, 32'd2);
    read_burst(8'h51, 32'h0000_0400, 4'd1, BURST_INC, -1, 0);

    // Word address wrap 0x3FFF -> 0x0000, upper and low address bits ignored
    fill_w(4'd1, 1'b0);
    wstb[0] = 4'hF; wstb[1] = 4'hF;
    write_burst(8'h60, 32'h1234_FFFF, 4'd1, BURST_INC);
    read_burst(8'h61, 32'hABCD_FFFD, 4'd1, BURST_INC, -1, 0);

    // Non-INCR bursts still transfer data but answer SLVERR
    fill_w(4'd2, 1'b0);
    write_burst(8'h70, 32'h0000_0600, 4'd2, 2'b00);
    read_burst(8'h71, 32'h0000_0600, 4'd2, 2'b10, 1, 2);

    // Randomized traffic in a small window so reads hit earlier writes
    for (int t = 0; t < 30; t++) begin
      tmp   = $urandom;
      word  = 14'h100 + 14'($urandom_range(0, 15));
      addr  = {tmp[31:16], word, tmp[1:0]};
      len   = 4'($urandom_range(0, 7));
      burst = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : BURST_INC;
      if ($urandom_range(0, 1) == 1) begin
        fill_w(len, 1'b1);
        write_burst(8'($urandom), addr, len, burst);
      end else begin
        read_burst(8'($urandom), addr, len, burst,
                   int'($urandom_range(0, 32'(len))), int'($urandom_range(0, 3)));
      end
    end

    // Reset in the middle of a read burst
    ar_phase(8'h80, 32'h0000_0020, 4'd3, BURST_INC);
    r_phase(8'h80, 32'h0000_0020, 4'd3, BURST_INC, 1, -1, 0);
    @(negedge clk);
    check("mid_rd_rvalid_before", {31'd0, RVALID}, 32'd1);
    RREADY = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rd_rvalid", {31'd0, RVALID}, 32'd0);
    check("mid_rd_idle",   {30'd0, AWREADY, ARREADY}, 32'd3);
    check("mid_rd_cs",     {31'd0, sram_cs}, 32'd0);
    RREADY = 1'b0;
    rst = 1'b0;

    // Reset in the middle of a write burst: no further SRAM write
    fill_w(4'd3, 1'b0);
    aw_phase(8'h90, 32'h0000_0800, 4'd3, BURST_INC);
    w_b_phase(8'h90, 32'h0000_0800, 4'd3, BURST_INC, 2);
    wr_before = sram_writes;
    WVALID = 1'b1; WDATA = 32'hBAD0BAD0; WSTRB = 4'hF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_wr_writes", sram_writes - wr_before, 32'd0);
    check("mid_wr_wready", {31'd0, WREADY}, 32'd0);
    check("mid_wr_bvalid", {31'd0, BVALID}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_wr_after",  sram_writes - wr_before, 32'd0);
    WVALID = 1'b0;
    read_burst(8'h91, 32'h0000_0800, 4'd3, BURST_INC, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
